// File: rtl/cheri_pkg.sv
// Shared types and constants for the temporal-safety revocation bitmap (tsmap) write path.
package cheri_pkg;

  localparam logic [31:0] TSMAP_HEAP_BASE_DEFAULT = 32'h8000_0000;
  localparam int          TSMAP_SIZE_DEFAULT      = 1024;

  // One tsmap bit covers 2^3 bytes; one tsmap word holds 2^5 bits.
  localparam int TSMAP_GRAN_SHIFT = 3;
  localparam int TSMAP_WORD_BITS  = 5;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] len;
    logic        set;
  } tsmap_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_RD,
    ST_WR,
    ST_RESP
  } painter_state_e;

  function automatic logic [31:0] span_mask(input logic [4:0] lo, input logic [4:0] hi);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (5'(i) >= lo) && (5'(i) <= hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/cheri_tsmap_mask_gen.sv
// Builds the bit mask for one tsmap word: first and last words of a range are partial,
// interior words are fully covered.
module cheri_tsmap_mask_gen
  import cheri_pkg::*;
(
  input  logic [26:0] w_i,
  input  logic [31:0] gs_i,
  input  logic [31:0] ge_i,
  output logic [31:0] mask_o
);

  logic [4:0] lo;
  logic [4:0] hi;

  always_comb begin
    lo     = (w_i == gs_i[31:TSMAP_WORD_BITS]) ? gs_i[TSMAP_WORD_BITS-1:0] : 5'd0;
    hi     = (w_i == ge_i[31:TSMAP_WORD_BITS]) ? ge_i[TSMAP_WORD_BITS-1:0] : 5'd31;
    mask_o = span_mask(lo, hi);
  end

endmodule

// File: rtl/cheri_tsmap_painter.sv
// Set/clear engine for the tsmap: accepts a byte range and read-modify-writes every
// tsmap word the range touches, then pulses a single completion response.
module cheri_tsmap_painter
  import cheri_pkg::*;
#(
  parameter logic [31:0] HeapBase  = TSMAP_HEAP_BASE_DEFAULT,
  parameter int          TSMapSize = TSMAP_SIZE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_base_i,
  input  logic [31:0] req_len_i,
  input  logic        req_set_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic        tsmap_cs_o,
  output logic        tsmap_we_o,
  output logic [15:0] tsmap_addr_o,
  output logic [31:0] tsmap_wdata_o,
  input  logic [31:0] tsmap_rdata_i
);

  painter_state_e state_q, state_d;

  tsmap_req_t  req_q;
  logic [31:0] gs_q;
  logic [31:0] ge_q;
  logic [26:0] word_q;
  logic        err_q;

  logic        accept;
  logic        lastWord;
  logic        lenZero;
  logic        rangeErr;
  logic [32:0] base33;
  logic [32:0] heap33;
  logic [32:0] sum33;
  logic [31:0] gsCalc;
  logic [32:0] geCalc;
  logic [31:0] wordMask;

  // Range decode uses 33 bits so that an end address past 2^32 is caught, not wrapped.
  always_comb begin
    base33   = {1'b0, req_q.base};
    heap33   = {1'b0, HeapBase};
    sum33    = base33 + {1'b0, req_q.len};
    gsCalc   = 32'((base33 - heap33) >> TSMAP_GRAN_SHIFT);
    geCalc   = (sum33 - 33'd1 - heap33) >> TSMAP_GRAN_SHIFT;
    lenZero  = (req_q.len == 32'd0);
    rangeErr = (req_q.base < HeapBase) || sum33[32] ||
               (geCalc[32:TSMAP_WORD_BITS] >= 28'(TSMapSize));
  end

  assign accept   = (state_q == ST_IDLE) && req_valid_i;
  assign lastWord = (word_q == ge_q[31:TSMAP_WORD_BITS]);

  cheri_tsmap_mask_gen u_mask_gen (
    .w_i    (word_q),
    .gs_i   (gs_q),
    .ge_i   (ge_q),
    .mask_o (wordMask)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: state_d = (lenZero || rangeErr) ? ST_RESP : ST_RD;
      ST_RD:   state_d = ST_WR;
      ST_WR:   state_d = lastWord ? ST_RESP : ST_RD;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= '0;
      gs_q   <= '0;
      ge_q   <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= '{base: req_base_i, len: req_len_i, set: req_set_i};
      end
      if (state_q == ST_CALC) begin
        gs_q   <= gsCalc;
        ge_q   <= geCalc[31:0];
        word_q <= gsCalc[31:TSMAP_WORD_BITS];
        err_q  <= !lenZero && rangeErr;
      end
      if ((state_q == ST_WR) && !lastWord) begin
        word_q <= word_q + 27'd1;
      end
    end
  end

  always_comb begin
    req_ready_o   = 1'b0;
    resp_valid_o  = 1'b0;
    resp_err_o    = 1'b0;
    busy_o        = 1'b1;
    tsmap_cs_o    = 1'b0;
    tsmap_we_o    = 1'b0;
    tsmap_addr_o  = 16'd0;
    tsmap_wdata_o = 32'd0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ST_RD: begin
        tsmap_cs_o   = 1'b1;
        tsmap_addr_o = word_q[15:0];
      end
      ST_WR: begin
        tsmap_cs_o    = 1'b1;
        tsmap_we_o    = 1'b1;
        tsmap_addr_o  = word_q[15:0];
        tsmap_wdata_o = req_q.set ? (tsmap_rdata_i | wordMask)
                                  : (tsmap_rdata_i & ~wordMask);
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
      end
      default: ;
    endcase
  end

endmodule
